// File: rtl/alu_flag_unit.sv
// Registered RISC-V flag set (zero/neg/carry/ovf) plus branch decision, with valid/ready, flush and stall-hold.
// Optional saturating statistics counters are built when ALU_FLAG_STATS_EN is defined.
module alu_flag_unit #(
  parameter int unsigned XLEN       = 32,
  parameter bit          RESET_ZERO = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic            is_branch,
  input  logic [2:0]      funct3,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            zero_flag,
  output logic            neg_flag,
  output logic            carry_flag,
  output logic            ovf_flag,
  output logic            branch_taken
`ifdef ALU_FLAG_STATS_EN
  ,
  output logic [CNT_W-1:0] zero_cnt,
  output logic [CNT_W-1:0] taken_cnt
`endif
);

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_cond_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
    logic taken;
  } flags_t;

  localparam flags_t FLAGS_RST = '{zero: RESET_ZERO, neg: 1'b0, carry: 1'b0, ovf: 1'b0, taken: 1'b0};

  logic [XLEN:0] diff;
  logic          eq, lt, ltu;
  flags_t        flags_new;
  flags_t        flags_d, flags_q;
  logic          valid_d, valid_q;
  logic          accept;

  // One subtract yields both unsigned borrow (top bit) and the signed-compare inputs.
  assign diff = {1'b0, operand_a} - {1'b0, operand_b};

  // NOTE: every signal driven from always_comb is given a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    flags_new       = '0;
    flags_new.zero  = (alu_result == '0);
    flags_new.neg   = alu_result[XLEN-1];
    flags_new.carry = diff[XLEN];
    flags_new.ovf   = (operand_a[XLEN-1] ^ operand_b[XLEN-1]) &
                      (operand_a[XLEN-1] ^ diff[XLEN-1]);
    eq  = (operand_a == operand_b);
    lt  = diff[XLEN-1] ^ flags_new.ovf;
    ltu = flags_new.carry;
    unique0 case (br_cond_e'(funct3))
      BR_EQ:   flags_new.taken = eq;
      BR_NE:   flags_new.taken = !eq;
      BR_LT:   flags_new.taken = lt;
      BR_GE:   flags_new.taken = !lt;
      BR_LTU:  flags_new.taken = ltu;
      BR_GEU:  flags_new.taken = !ltu;
      default: flags_new.taken = 1'b0;
    endcase
    flags_new.taken = flags_new.taken & is_branch;
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Flags are sticky: they change only on an accepted transaction, so a drained or flushed stage keeps the last result.
  always_comb begin
    valid_d = valid_q && !out_ready;
    flags_d = flags_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      flags_d = flags_new;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      flags_q <= FLAGS_RST;
    end else begin
      valid_q <= valid_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid    = valid_q;
  assign zero_flag    = flags_q.zero;
  assign neg_flag     = flags_q.neg;
  assign carry_flag   = flags_q.carry;
  assign ovf_flag     = flags_q.ovf;
  assign branch_taken = flags_q.taken;

`ifdef ALU_FLAG_STATS_EN
  logic [CNT_W-1:0] zero_cnt_d, zero_cnt_q;
  logic [CNT_W-1:0] taken_cnt_d, taken_cnt_q;

  // Counters saturate at all-ones rather than wrapping.
  always_comb begin
    zero_cnt_d  = zero_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (accept && flags_new.zero && (zero_cnt_q != '1)) begin
      zero_cnt_d = zero_cnt_q + CNT_W'(1);
    end
    if (accept && flags_new.taken && (taken_cnt_q != '1)) begin
      taken_cnt_d = taken_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_cnt_q  <= '0;
      taken_cnt_q <= '0;
    end else begin
      zero_cnt_q  <= zero_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign zero_cnt  = zero_cnt_q;
  assign taken_cnt = taken_cnt_q;
`endif

endmodule
